// File: rtl/decode_stage.sv
// decode_stage: RV32I decode into the execute stage register; writeback bypass under DECODE_WB_BYPASS_EN.
// One-cycle decode-to-execute latency; stall_DE holds fetch on ex_stall or a one-cycle load-use bubble.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_valid,
  input  logic [31:0] de_instr,
  input  logic [31:0] de_pc,
  input  logic [63:0] de_order,
  input  logic        flush,
  input  logic        ex_stall,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall_DE,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [63:0] ex_order,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic [6:0]  ex_opcode,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic        ex_is_load,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] order;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        is_load;
    logic        illegal;
  } ex_t;

  ex_t         ex_q, ex_d, dec;
  logic [6:0]  op;
  logic [31:0] imm;
  logic        legal, use_rs1, use_rs2, load_use;
  logic [31:0] rs1_val, rs2_val;

  assign op       = de_instr[6:0];
  assign rs1_addr = de_instr[19:15];
  assign rs2_addr = de_instr[24:20];

  always_comb begin
    imm     = '0;
    legal   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: imm = {de_instr[31:12], 12'b0};
      OP_JAL:    imm = {{12{de_instr[31]}}, de_instr[19:12], de_instr[20], de_instr[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        imm     = {{20{de_instr[31]}}, de_instr[31:20]};
        use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        imm     = {{20{de_instr[31]}}, de_instr[7], de_instr[30:25], de_instr[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_STORE: begin
        imm     = {{20{de_instr[31]}}, de_instr[31:25], de_instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_rdata;
  assign rs2_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_rdata;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
  assign rs1_val   = rs1_rdata;
  assign rs2_val   = rs2_rdata;
`endif

  always_comb begin
    dec.valid    = de_valid;
    dec.pc       = de_pc;
    dec.instr    = de_instr;
    dec.order    = de_order;
    dec.rd       = de_instr[11:7];
    dec.rs1      = rs1_addr;
    dec.rs2      = rs2_addr;
    dec.funct3   = de_instr[14:12];
    dec.funct7   = de_instr[31:25];
    dec.opcode   = op;
    dec.imm      = imm;
    dec.rs1_data = rs1_val;
    dec.rs2_data = rs2_val;
    dec.is_load  = de_valid && (op == OP_LOAD);
    dec.illegal  = de_valid && !legal;
  end

  // Bubble valid is zero, so a load in ex can only stall the consumer once.
  assign load_use = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && de_valid &&
                    ((use_rs1 && ex_q.rd == rs1_addr) || (use_rs2 && ex_q.rd == rs2_addr));

  assign stall_DE = rst_n && !flush && (ex_stall || load_use);

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d       = dec;
      ex_d.valid = 1'b0;
    end else if (ex_stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d       = dec;
      ex_d.valid = 1'b0;
    end else begin
      ex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      ex_q.pc <= RESET_PC;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_instr    = ex_q.instr;
  assign ex_order    = ex_q.order;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7   = ex_q.funct7;
  assign ex_opcode   = ex_q.opcode;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_is_load  = ex_q.is_load;
  assign ex_illegal  = ex_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter RESET_PC, 32'h1eceb000, ex_pc value after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous reset, active-low.
REQ-004 de_valid / de_instr / de_pc / de_order  in  1/32/32/64  decode stage register contents from fetch.
REQ-005 flush  in  1  redirect from execute; kill the instruction in decode.
REQ-006 ex_stall  in  1  execute cannot accept this cycle.
REQ-007 rs1_addr / rs2_addr  out  5/5  register file read addresses, combinational from de_instr[19:15] / [24:20].
REQ-008 rs1_rdata / rs2_rdata  in  32/32  register file read data, same cycle.
REQ-009 wb_we / wb_rd / wb_data  in  1/5/32  writeback port, used for bypass.
REQ-010 stall_DE  out  1  hold the fetch-to-decode register and the fetch request.
REQ-011 ex_valid / ex_pc / ex_instr / ex_order  out  1/32/32/64  execute stage register.
REQ-012 ex_rd / ex_rs1 / ex_rs2 / ex_funct3 / ex_funct7 / ex_opcode  out  5/5/5/3/7/7  decoded fields, registered.
REQ-013 ex_imm / ex_rs1_data / ex_rs2_data  out  32/32/32  sign-extended immediate and operands, registered.
REQ-014 ex_is_load / ex_illegal  out  1/1  registered flags.

Function
REQ-015 Immediate: I, S, B, U and J forms per RV32I, sign-extended from instr[31]; ex_imm = 0 for R-type.
REQ-016 Opcode classes:
- lui 0110111, auipc 0010111, jal 1101111, jalr 1100111
- branch 1100011, load 0000011, store 0100011
- op-imm 0010011, op 0110011
REQ-017 Any other opcode with de_valid = 1 sets ex_illegal = 1 and ex_imm = 0; the instruction still advances with ex_valid = 1.
REQ-018 Source usage:
- rs1: jalr, branch, load, store, op-imm, op
- rs2: branch, store, op
REQ-019 Load-use hazard = ex_valid & ex_is_load & ex_rd != 0 & de_valid & (ex_rd == used rs1 or ex_rd == used rs2).
REQ-020 Priority, highest first: reset, flush, ex_stall, load-use, normal advance.
REQ-021 Flush: next-cycle ex_valid = 0; stall_DE = 0.
REQ-022 ex_stall with no flush: all ex_* registers hold; stall_DE = 1.
REQ-023 Load-use: ex_valid <= 0 (bubble), other ex_* may change, stall_DE = 1 for exactly one cycle per hazard.
REQ-024 Normal: all ex_* registers load from decode; ex_valid <= de_valid; stall_DE = 0.
REQ-025 An instruction with de_valid = 0 advances as a bubble and never raises a hazard.
REQ-026 stall_DE is combinational from current inputs and registered state, with no flop in its path.
REQ-027 Decode-to-execute latency is 1 cycle with no hazard.

Reset
REQ-028 While rst_n = 0 at a clock edge, every output loads its reset value:
- ex_valid = 0, ex_pc = RESET_PC
- all other ex_* registers = 0
REQ-029 stall_DE = 0 while rst_n = 0.
REQ-030 Reset asserted mid-stall or mid-bubble discards the stall or bubble; the first cycle after release is a normal cycle.

Configuration
REQ-031 Macro DECODE_WB_BYPASS_EN, when defined:
- if wb_we & wb_rd != 0 & wb_rd == rsN_addr, ex_rsN_data loads wb_data instead of rsN_rdata.
REQ-032 When DECODE_WB_BYPASS_EN is undefined, ex_rsN_data always loads rsN_rdata, and the wb_* ports are present but ignored.

Verification
REQ-033 de_instr 32'hfff00093 (addi x1,x0,-1), de_valid = 1 -> next cycle ex_valid = 1, ex_rd = 1, ex_imm = 32'hffffffff, ex_illegal = 0.
REQ-034 Load-use hazard:
- stimulus: ex holds lw x5 (ex_is_load = 1, ex_rd = 5); decode holds add x6,x5,x7
- response: stall_DE = 1 for one cycle, then ex_valid = 0, then the add enters ex.
REQ-035 ex_stall = 1 for 3 cycles -> ex_* registers unchanged and stall_DE = 1 for all 3 cycles.
REQ-036 flush = 1 and ex_stall = 1 in the same cycle -> next-cycle ex_valid = 0, stall_DE = 0.
REQ-037 wb_we = 1, wb_rd = 3, wb_data = 32'hdeadbeef, rs1_addr = 3, rs1_rdata = 0 -> ex_rs1_data = 32'hdeadbeef with DECODE_WB_BYPASS_EN defined, 0 without it.
REQ-038 rst_n = 0 during a load-use stall -> next cycle ex_valid = 0, ex_pc = 32'h1eceb000, stall_DE = 0; de_instr 32'h0000007f after release -> ex_illegal = 1.
